fetch_unit: RTL and testbench

- Instruction-fetch stage directly upstream of the program-counter block.
- Generates the free-running four-phase fetch sequence (Q1–Q4) that the PC block steps on.
- Addresses program ROM with the current PC and latches the returned word into the instruction register (IR) consumed by decode/execute and by the PC block.
- Squashes the fetched word to NOP when the PC block requests a skip (skip-tests, CALL, RETLW, writes to PCL).

---
 rtl/fetch_unit.sv | 89 ++++++++
 tb/tb_fetch_unit.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: four-phase Q1-Q4 sequencer, ROM addressing and the
// instruction register, with single-word squash on request from the PC block.
module fetch_unit #(
  parameter int                    INST_WIDTH    = 12,
  parameter int                    PC_WIDTH      = 9,
  parameter int                    FE_STATE_BITS = 2,
  parameter logic [INST_WIDTH-1:0] NOP_WORD      = 12'h000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [PC_WIDTH-1:0]      PC,
  input  logic                     skip,
  input  logic                     stall,
  input  logic [INST_WIDTH-1:0]    romData,
  output logic [PC_WIDTH-1:0]      romAddr,
  output logic                     romEn,
  output logic [FE_STATE_BITS-1:0] fetchState,
  output logic [INST_WIDTH-1:0]    IR,
  output logic                     irSquashed,
  output logic [7:0]               squashCount
);

  localparam logic [FE_STATE_BITS-1:0] Q1 = FE_STATE_BITS'(0);
  localparam logic [FE_STATE_BITS-1:0] Q2 = FE_STATE_BITS'(1);
  localparam logic [FE_STATE_BITS-1:0] Q3 = FE_STATE_BITS'(2);
  localparam logic [FE_STATE_BITS-1:0] Q4 = FE_STATE_BITS'(3);

  logic [FE_STATE_BITS-1:0] state_q, state_d;
  logic [PC_WIDTH-1:0]      rom_addr_q, rom_addr_d;
  logic [INST_WIDTH-1:0]    ir_q, ir_d;
  logic                     ir_squashed_q, ir_squashed_d;
  logic [7:0]               squash_count_q, squash_count_d;

  // A stall freezes every register; the whole next-state update is gated by it.
  always_comb begin
    state_d        = state_q;
    rom_addr_d     = rom_addr_q;
    ir_d           = ir_q;
    ir_squashed_d  = ir_squashed_q;
    squash_count_d = squash_count_q;
    if (!stall) begin
      case (state_q)
        Q1: begin
          state_d = Q2;
          if (skip) begin
            ir_d          = NOP_WORD;
            ir_squashed_d = 1'b1;
            if (squash_count_q != 8'hFF) squash_count_d = squash_count_q + 8'd1;
          end
        end
        Q2: begin
          state_d    = Q3;
          rom_addr_d = PC;
        end
        Q3: state_d = Q4;
        default: begin
          state_d       = Q1;
          ir_d          = romData;
          ir_squashed_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= Q1;
      rom_addr_q     <= '0;
      ir_q           <= NOP_WORD;
      ir_squashed_q  <= 1'b1;
      squash_count_q <= 8'd0;
    end else begin
      state_q        <= state_d;
      rom_addr_q     <= rom_addr_d;
      ir_q           <= ir_d;
      ir_squashed_q  <= ir_squashed_d;
      squash_count_q <= squash_count_d;
    end
  end

  // Dropping the strobe while held in Q3 makes the ROM re-read on resume.
  assign romEn       = (state_q == Q3) && !stall;
  assign romAddr     = rom_addr_q;
  assign fetchState  = state_q;
  assign IR          = ir_q;
  assign irSquashed  = ir_squashed_q;
  assign squashCount = squash_count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a phase-level reference model pushes the
// expected architectural state per clock, a negedge monitor pops and compares.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [8:0]  PC = '0;
  logic        skip = 1'b0;
  logic        stall = 1'b0;
  logic [11:0] romData = '0;
  logic [8:0]  romAddr;
  logic        romEn;
  logic [1:0]  fetchState;
  logic [11:0] IR;
  logic        irSquashed;
  logic [7:0]  squashCount;

  fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .PC(PC), .skip(skip), .stall(stall),
    .romData(romData), .romAddr(romAddr), .romEn(romEn),
    .fetchState(fetchState), .IR(IR), .irSquashed(irSquashed),
    .squashCount(squashCount)
  );

  always #5 clk = ~clk;

  logic [11:0] rom [512];

  // Synchronous ROM, one-cycle latency, updates only when strobed.
  always @(posedge clk) if (romEn) romData <= rom[romAddr];

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    int ph;
    int addr;
    int ir;
    int sq;
    int cnt;
  } exp_t;

  exp_t sb[$];

  // Reference model: phase counter 0..3 (Q1..Q4), instruction word taken
  // straight from the ROM array at the address captured in Q2.
  int m_ph = 0, m_addr = 0, m_ir = 0, m_sq = 1, m_cnt = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ph = 0; m_addr = 0; m_ir = 0; m_sq = 1; m_cnt = 0;
      sb.delete();
    end else begin
      if (!stall) begin
        if (m_ph == 0 && skip) begin
          m_ir = 0; m_sq = 1;
          if (m_cnt < 255) m_cnt = m_cnt + 1;
        end else if (m_ph == 1) begin
          m_addr = int'(PC);
        end else if (m_ph == 3) begin
          m_ir = int'(rom[m_addr]); m_sq = 0;
        end
        m_ph = (m_ph + 1) % 4;
      end
      sb.push_back('{m_ph, m_addr, m_ir, m_sq, m_cnt});
    end
  end

  // Monitor: compares on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("fetchState", int'(fetchState), e.ph);
      chk("romAddr", int'(romAddr), e.addr);
      chk("IR", int'(IR), e.ir);
      chk("irSquashed", int'(irSquashed), e.sq);
      chk("squashCount", int'(squashCount), e.cnt);
      chk("romEn", int'(romEn), int'(e.ph == 2 && !stall));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // One instruction cycle: skip raised during phase sk (-1 none), stall held
  // for st clocks on entering Q3.
  task automatic cyc(input int pc, input int sk, input int st);
    for (int ph = 0; ph < 4; ph++) begin
      PC   = 9'(pc);
      skip = (ph == sk);
      if (ph == 2 && st > 0) begin
        stall = 1'b1;
        repeat (st) tick();
        stall = 1'b0;
      end
      tick();
    end
    skip = 1'b0;
  endtask

  // Async reset asserted between edges, checked before any clock edge.
  task automatic async_reset();
    #1 rst_n = 1'b0;
    #1;
    chk("rst fetchState", int'(fetchState), 0);
    chk("rst IR", int'(IR), 0);
    chk("rst irSquashed", int'(irSquashed), 1);
    chk("rst squashCount", int'(squashCount), 0);
    chk("rst romAddr", int'(romAddr), 0);
    chk("rst romEn", int'(romEn), 0);
    skip = 1'b0; stall = 1'b0; PC = '0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 512; i++) rom[i] = 12'($urandom);
    rom[0] = 12'hA05;
    repeat (3) @(posedge clk);
    #2;
    chk("init IR", int'(IR), 0);
    chk("init irSquashed", int'(irSquashed), 1);
    rst_n = 1'b1;

    // First instruction after reset release.
    cyc(0, -1, 0);
    chk("first IR", int'(IR), 12'hA05);

    // Straight-line fetch, squash in Q1, skip in Q3 ignored, stall in Q3.
    async_reset();
    rom[0] = 12'h0C1; rom[1] = 12'h0C2; rom[2] = 12'h0C3; rom[3] = 12'h0C4;
    cyc(0, -1, 0);
    cyc(1, -1, 0);
    chk("line IR", int'(IR), 12'h0C2);
    cyc(2, 0, 0);
    cyc(3, 2, 0);
    cyc(2, -1, 5);
    chk("stall IR", int'(IR), 12'h0C3);

    // Reset in the middle of Q3 with a valid word in IR.
    PC = 9'd1;
    tick(); tick();
    async_reset();

    // Saturating squash counter.
    for (int i = 0; i < 300; i++) cyc(i, 0, 0);
    chk("sat squashCount", int'(squashCount), 255);

    // Randomized traffic, including wrap of PC and a mid-run async reset.
    async_reset();
    for (int i = 0; i < 3000; i++) begin
      PC    = 9'($urandom);
      skip  = ($urandom_range(0, 2) == 0);
      stall = ($urandom_range(0, 4) == 0);
      if (i == 1500) async_reset();
      else tick();
    end
    stall = 1'b0; skip = 1'b0;
    repeat (4) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
